// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side handshake signals shared by
// the data-memory port arbiter and its clients.
interface mem_port_arbiter_if #(
  parameter int xlen = 32
);
  logic            f_req_v;
  logic [xlen-1:0] f_adr;
  logic            f_flush;
  logic            f_gnt;
  logic            f_rsp_v;
  logic [xlen-1:0] f_rsp_data;

  logic            l_req_v;
  logic            l_we;
  logic [xlen-1:0] l_adr;
  logic [xlen-1:0] l_wdata;
  logic [3:0]      l_strobe;
  logic            l_gnt;
  logic            l_rsp_v;
  logic [xlen-1:0] l_rsp_data;

  logic            mem_r_v;
  logic            mem_w_v;
  logic [xlen-1:0] mem_adr;
  logic [xlen-1:0] mem_wdata;
  logic [3:0]      mem_strobe;
  logic            mem_hit;
  logic [xlen-1:0] mem_rdata;

  // Arbiter side: owns grants, responses and the memory request.
  modport master (
    input  f_req_v, f_adr, f_flush,
    input  l_req_v, l_we, l_adr, l_wdata, l_strobe,
    input  mem_hit, mem_rdata,
    output f_gnt, f_rsp_v, f_rsp_data,
    output l_gnt, l_rsp_v, l_rsp_data,
    output mem_r_v, mem_w_v, mem_adr, mem_wdata, mem_strobe
  );

  // Client/memory side.
  modport slave (
    output f_req_v, f_adr, f_flush,
    output l_req_v, l_we, l_adr, l_wdata, l_strobe,
    output mem_hit, mem_rdata,
    input  f_gnt, f_rsp_v, f_rsp_data,
    input  l_gnt, l_rsp_v, l_rsp_data,
    input  mem_r_v, mem_w_v, mem_adr, mem_wdata, mem_strobe
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (F) and the LSU (L).
// L has priority; a consecutive-grant counter bounds how long F can starve.
module mem_port_arbiter #(
  parameter int xlen       = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CW = $clog2(MAX_CONSEC + 1);

  state_t          state_reg;
  logic            owner_l_reg;
  logic [CW-1:0]   consec_reg;
  logic            cancel_reg;
  logic            we_reg;
  logic [xlen-1:0] adr_reg;
  logic [xlen-1:0] wdata_reg;
  logic [3:0]      strobe_reg;
  logic            mem_r_v_reg;
  logic            mem_w_v_reg;

  logic idle_now;
  logic hit_now;
  logic f_win;
  logic l_win;
  logic f_rsp_v_w;
  logic l_rsp_v_w;

  always_comb begin
    idle_now  = (state_reg == IDLE) && !rst;
    hit_now   = (state_reg == BUSY) && !rst && bus.mem_hit;
    // A flush cycle never grants F; once L has won MAX_CONSEC times in a row, F goes first.
    f_win     = idle_now && bus.f_req_v && !bus.f_flush &&
                (!bus.l_req_v || (consec_reg == CW'(MAX_CONSEC)));
    l_win     = idle_now && bus.l_req_v && !f_win;
    f_rsp_v_w = hit_now && !owner_l_reg && !cancel_reg && !bus.f_flush;
    l_rsp_v_w = hit_now && owner_l_reg;
  end

  assign bus.f_gnt      = f_win;
  assign bus.l_gnt      = l_win;
  assign bus.f_rsp_v    = f_rsp_v_w;
  assign bus.f_rsp_data = f_rsp_v_w ? bus.mem_rdata : '0;
  assign bus.l_rsp_v    = l_rsp_v_w;
  assign bus.l_rsp_data = (l_rsp_v_w && !we_reg) ? bus.mem_rdata : '0;
  assign bus.mem_r_v    = mem_r_v_reg;
  assign bus.mem_w_v    = mem_w_v_reg;
  assign bus.mem_adr    = adr_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.mem_strobe = strobe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_l_reg <= 1'b0;
      consec_reg  <= '0;
      cancel_reg  <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      wdata_reg   <= '0;
      strobe_reg  <= '0;
      mem_r_v_reg <= 1'b0;
      mem_w_v_reg <= 1'b0;
    end else begin
      if (!bus.f_req_v || f_win) begin
        consec_reg <= '0;
      end else if (l_win && (consec_reg != CW'(MAX_CONSEC))) begin
        consec_reg <= consec_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (l_win) begin
            state_reg   <= BUSY;
            owner_l_reg <= 1'b1;
            we_reg      <= bus.l_we;
            adr_reg     <= bus.l_adr;
            wdata_reg   <= bus.l_wdata;
            strobe_reg  <= bus.l_strobe;
            mem_r_v_reg <= !bus.l_we;
            mem_w_v_reg <= bus.l_we;
          end else if (f_win) begin
            // Fetches are full-word reads with no write payload.
            state_reg   <= BUSY;
            owner_l_reg <= 1'b0;
            we_reg      <= 1'b0;
            adr_reg     <= bus.f_adr;
            wdata_reg   <= '0;
            strobe_reg  <= 4'hF;
            mem_r_v_reg <= 1'b1;
            mem_w_v_reg <= 1'b0;
          end
        end
        BUSY: begin
          if (bus.mem_hit) begin
            state_reg   <= IDLE;
            cancel_reg  <= 1'b0;
            mem_r_v_reg <= 1'b0;
            mem_w_v_reg <= 1'b0;
          end else if (bus.f_flush && !owner_l_reg) begin
            cancel_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int MAXC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.xlen(XLEN)) bus ();

  mem_port_arbiter #(.xlen(XLEN), .MAX_CONSEC(MAXC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Model: the one outstanding access (if any) and F's current wait streak.
  bit          m_busy, m_owner_l, m_we, m_cancel;
  logic [31:0] m_adr, m_wdata;
  logic [3:0]  m_strobe;
  int          m_streak;

  // Expected grants this cycle, used by the requesters to retire a request.
  bit e_f_gnt, e_l_gnt;

  // Snapshot of DUT outputs for the current cycle.
  bit          s_f_gnt, s_l_gnt, s_f_rsp_v, s_l_rsp_v, s_r_v, s_w_v;
  logic [31:0] s_adr, s_f_data, s_l_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.f_req_v = 1'b0; bus.f_adr = '0; bus.f_flush = 1'b0;
    bus.l_req_v = 1'b0; bus.l_we = 1'b0; bus.l_adr = '0;
    bus.l_wdata = '0; bus.l_strobe = '0;
    bus.mem_hit = 1'b0; bus.mem_rdata = '0;
  endtask

  // Inputs are already driven (after a negedge). Sample, compare, advance model.
  task automatic cycle();
    bit idle, hit, e_f_rsp, e_l_rsp, e_r_v, e_w_v;
    #1;
    s_f_gnt = bus.f_gnt;   s_l_gnt = bus.l_gnt;
    s_f_rsp_v = bus.f_rsp_v; s_l_rsp_v = bus.l_rsp_v;
    s_r_v = bus.mem_r_v;   s_w_v = bus.mem_w_v;
    s_adr = bus.mem_adr;   s_f_data = bus.f_rsp_data; s_l_data = bus.l_rsp_data;

    e_r_v   = m_busy && !m_we;
    e_w_v   = m_busy && m_we;
    idle    = !m_busy && !rst;
    e_f_gnt = idle && bus.f_req_v && !bus.f_flush && (!bus.l_req_v || m_streak >= MAXC);
    e_l_gnt = idle && bus.l_req_v && !e_f_gnt;
    hit     = m_busy && !rst && bus.mem_hit;
    e_f_rsp = hit && !m_owner_l && !m_cancel && !bus.f_flush;
    e_l_rsp = hit && m_owner_l;

    chk("ctrl{fg,lg,fr,lr,rv,wv}",
        128'({s_f_gnt, s_l_gnt, s_f_rsp_v, s_l_rsp_v, s_r_v, s_w_v}),
        128'({e_f_gnt, e_l_gnt, e_f_rsp, e_l_rsp, e_r_v, e_w_v}));
    chk("membus{adr,wdata,strobe}",
        128'({bus.mem_adr, bus.mem_wdata, bus.mem_strobe}),
        128'({m_adr, m_wdata, m_strobe}));
    if (e_f_rsp) chk("f_rsp_data", 128'(s_f_data), 128'(bus.mem_rdata));
    if (e_l_rsp) chk("l_rsp_data", 128'(s_l_data), 128'(m_we ? 32'h0 : bus.mem_rdata));

    if (rst) begin
      m_busy = 0; m_owner_l = 0; m_we = 0; m_cancel = 0;
      m_adr = '0; m_wdata = '0; m_strobe = '0; m_streak = 0;
    end else begin
      if (!bus.f_req_v || e_f_gnt) m_streak = 0;
      else if (e_l_gnt && m_streak < MAXC) m_streak++;
      if (e_l_gnt) begin
        m_busy = 1; m_owner_l = 1; m_we = bus.l_we;
        m_adr = bus.l_adr; m_wdata = bus.l_wdata; m_strobe = bus.l_strobe;
        $display("cycle %0d: grant L %s adr=%h wdata=%h strobe=%h", cyc_no,
                 bus.l_we ? "WR" : "RD", bus.l_adr, bus.l_wdata, bus.l_strobe);
      end else if (e_f_gnt) begin
        m_busy = 1; m_owner_l = 0; m_we = 0;
        m_adr = bus.f_adr; m_wdata = '0; m_strobe = 4'hF;
        $display("cycle %0d: grant F RD adr=%h", cyc_no, bus.f_adr);
      end else if (m_busy) begin
        if (bus.mem_hit) begin
          $display("cycle %0d: complete %s adr=%h rsp=%0d", cyc_no,
                   m_owner_l ? "L" : "F", m_adr, e_f_rsp || e_l_rsp);
          m_busy = 0; m_cancel = 0;
        end else if (bus.f_flush && !m_owner_l) begin
          m_cancel = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
  endtask

  initial begin
    bit f_pend, l_pend;
    int n, cyc;
    logic [9:0] order;

    m_busy = 0; m_owner_l = 0; m_we = 0; m_cancel = 0;
    m_adr = '0; m_wdata = '0; m_strobe = '0; m_streak = 0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;

    // Reset state
    cycle();
    chk("reset_ctrl", 128'({s_f_gnt, s_l_gnt, s_r_v, s_w_v}), 128'(4'b0000));
    chk("reset_adr", 128'(s_adr), 128'(32'h0));

    // L write, hit on the third busy cycle
    bus.l_req_v = 1; bus.l_we = 1; bus.l_adr = 32'h100;
    bus.l_wdata = 32'hDEADBEEF; bus.l_strobe = 4'hF;
    cycle();
    chk("lw_gnt", 128'(s_l_gnt), 128'(1'b1));
    bus.l_req_v = 0;
    cycle();
    chk("lw_c1", 128'({s_w_v, s_adr}), 128'({1'b1, 32'h100}));
    cycle();
    chk("lw_c2", 128'({s_w_v, s_adr, bus.mem_wdata}), 128'({1'b1, 32'h100, 32'hDEADBEEF}));
    bus.mem_hit = 1;
    cycle();
    chk("lw_rsp", 128'({s_w_v, s_l_rsp_v, s_l_data}), 128'({1'b1, 1'b1, 32'h0}));
    bus.mem_hit = 0;
    cycle();
    chk("lw_idle", 128'(s_w_v), 128'(1'b0));

    // F read with immediate hit
    bus.f_req_v = 1; bus.f_adr = 32'h40;
    cycle();
    chk("fr_gnt", 128'(s_f_gnt), 128'(1'b1));
    bus.f_req_v = 0; bus.mem_hit = 1; bus.mem_rdata = 32'h12345678;
    cycle();
    chk("fr_rsp", 128'({s_r_v, s_f_rsp_v, s_f_data}), 128'({1'b1, 1'b1, 32'h12345678}));
    bus.mem_hit = 0;
    cycle();
    chk("fr_idle", 128'(s_r_v), 128'(1'b0));

    // Both requesting continuously, immediate hits
    bus.f_req_v = 1; bus.l_req_v = 1; bus.l_we = 0; bus.l_adr = 32'h300; bus.f_adr = 32'h500;
    order = '0; n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      bus.mem_hit = m_busy;
      cycle();
      if (s_f_gnt && s_l_gnt) chk("both_gnt", 128'(2'b11), 128'(2'b01));
      if (s_f_gnt || s_l_gnt) begin
        order = {order[8:0], s_l_gnt};
        n++;
      end
    end
    chk("grant_count", 128'(n), 128'(10));
    chk("grant_order", 128'(order), 128'(10'b1111011110));
    idle_inputs(); bus.mem_hit = 1;
    cycle();
    bus.mem_hit = 0;

    // Flush during an F access: response suppressed, next F normal
    bus.f_req_v = 1; bus.f_adr = 32'h80;
    cycle();
    chk("fl_gnt", 128'(s_f_gnt), 128'(1'b1));
    bus.f_req_v = 0; bus.f_flush = 1;
    cycle();
    chk("fl_c1", 128'(s_r_v), 128'(1'b1));
    bus.f_flush = 0;
    cycle();
    chk("fl_c2", 128'(s_r_v), 128'(1'b1));
    bus.mem_hit = 1; bus.mem_rdata = 32'hCAFEF00D;
    cycle();
    chk("fl_hit", 128'({s_r_v, s_f_rsp_v}), 128'({1'b1, 1'b0}));
    bus.mem_hit = 0; bus.f_req_v = 1; bus.f_adr = 32'h84;
    cycle();
    chk("fl_next_gnt", 128'(s_f_gnt), 128'(1'b1));
    bus.f_req_v = 0; bus.mem_hit = 1; bus.mem_rdata = 32'h0BADCAFE;
    cycle();
    chk("fl_next_rsp", 128'({s_f_rsp_v, s_f_data}), 128'({1'b1, 32'h0BADCAFE}));
    bus.mem_hit = 0;

    // Reset while an L read is outstanding
    bus.l_req_v = 1; bus.l_we = 0; bus.l_adr = 32'h200;
    cycle();
    chk("rb_gnt", 128'(s_l_gnt), 128'(1'b1));
    bus.l_req_v = 0;
    cycle();
    chk("rb_busy", 128'(s_r_v), 128'(1'b1));
    rst = 1;
    cycle();
    rst = 0; bus.l_req_v = 1; bus.l_adr = 32'h204;
    cycle();
    chk("rb_after", 128'({s_r_v, s_l_rsp_v, s_l_gnt}), 128'(3'b001));
    bus.l_req_v = 0; bus.mem_hit = 1; bus.mem_rdata = 32'h55AA55AA;
    cycle();
    chk("rb_rsp", 128'({s_l_rsp_v, s_l_data}), 128'({1'b1, 32'h55AA55AA}));
    bus.mem_hit = 0;

    // F only: each request granted in the first idle cycle
    n = 0; cyc = 0;
    bus.f_req_v = 1;
    for (int i = 0; i < 40 && n < 10; i++) begin
      bus.f_adr = 32'(n * 4);
      bus.mem_hit = m_busy;
      cycle();
      cyc++;
      if (s_f_gnt) n++;
    end
    chk("f_only_count", 128'(n), 128'(10));
    chk("f_only_cycles", 128'(cyc), 128'(19));
    idle_inputs(); bus.mem_hit = 1;
    cycle();
    bus.mem_hit = 0;

    // Randomized traffic
    f_pend = 0; l_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!f_pend && $urandom_range(2) == 0) begin
        f_pend = 1;
        bus.f_adr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!l_pend && $urandom_range(2) == 0) begin
        l_pend = 1;
        bus.l_we = 1'($urandom_range(1));
        bus.l_adr = $urandom();
        bus.l_wdata = $urandom();
        bus.l_strobe = 4'($urandom_range(15));
      end
      bus.f_req_v   = f_pend;
      bus.l_req_v   = l_pend;
      bus.f_flush   = ($urandom_range(7) == 0);
      bus.mem_hit   = m_busy && ($urandom_range(1) == 1);
      bus.mem_rdata = $urandom();
      rst           = ($urandom_range(199) == 0);
      cycle();
      if (e_f_gnt) f_pend = 0;
      if (e_l_gnt) l_pend = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
